// File: rtl/traffic_lights_xn.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : traffic_lights_xn
// Purpose  : N-approach round-robin intersection controller on a 2 kHz tick.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_lights_xn #(
   parameter int NUM_DIR               = 2,
   parameter int BLINK_HALF_PERIOD_MS  = 250,
   parameter int BLINK_GREEN_TIME_TICK = 3,
   parameter int RED_YELLOW_MS         = 1000,
   parameter int DEF_GREEN_MS          = 5000,
   parameter int DEF_YELLOW_MS         = 1000,
   parameter int DEF_ALL_RED_MS        = 500,
   localparam int DIR_W = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
   input  logic               clk_2k_i,
   input  logic               srst_i,
   input  logic               cmd_valid_i,
   input  logic [2:0]         cmd_type_i,
   input  logic [DIR_W-1:0]   cmd_dir_i,
   input  logic [15:0]        cmd_data_i,
   output logic [NUM_DIR-1:0] red_o,
   output logic [NUM_DIR-1:0] yellow_o,
   output logic [NUM_DIR-1:0] green_o,
   output logic [DIR_W-1:0]   active_dir_o
);

   localparam int CLK_FREQ_KHZ = 2;
   localparam int LIM_W        = 17;

   localparam logic [LIM_W-1:0] BLINK_HALF_CYC  = LIM_W'(BLINK_HALF_PERIOD_MS * CLK_FREQ_KHZ);
   localparam logic [LIM_W-1:0] BLINK_LAST_CYC  = LIM_W'(2 * BLINK_HALF_PERIOD_MS * CLK_FREQ_KHZ - 1);
   localparam logic [LIM_W-1:0] GREEN_BLINK_CYC =
      LIM_W'(BLINK_GREEN_TIME_TICK * 2 * BLINK_HALF_PERIOD_MS * CLK_FREQ_KHZ);
   localparam logic [LIM_W-1:0] RED_YELLOW_CYC  = LIM_W'(RED_YELLOW_MS * CLK_FREQ_KHZ);
   localparam logic [LIM_W-1:0] DEF_GREEN_CYC   = LIM_W'(DEF_GREEN_MS * CLK_FREQ_KHZ);
   localparam logic [LIM_W-1:0] DEF_YELLOW_CYC  = LIM_W'(DEF_YELLOW_MS * CLK_FREQ_KHZ);
   localparam logic [LIM_W-1:0] DEF_ALL_RED_CYC = LIM_W'(DEF_ALL_RED_MS * CLK_FREQ_KHZ);
   localparam logic [DIR_W-1:0] DIR_LAST        = DIR_W'(NUM_DIR - 1);

   localparam logic [2:0] CMD_ON          = 3'd0;
   localparam logic [2:0] CMD_OFF         = 3'd1;
   localparam logic [2:0] CMD_MANUAL      = 3'd2;
   localparam logic [2:0] CMD_SET_GREEN   = 3'd3;
   localparam logic [2:0] CMD_SET_YELLOW  = 3'd4;
   localparam logic [2:0] CMD_SET_ALL_RED = 3'd5;

   typedef enum logic [2:0] {
      ST_ALL_RED     = 3'd0,
      ST_RED_YELLOW  = 3'd1,
      ST_GREEN       = 3'd2,
      ST_GREEN_BLINK = 3'd3,
      ST_YELLOW      = 3'd4,
      ST_MANUAL      = 3'd5,
      ST_OFF         = 3'd6
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [DIR_W-1:0]   r_dir;
   logic [DIR_W-1:0]   w_dir_next;
   logic [LIM_W-1:0]   r_cnt;
   logic [LIM_W-1:0]   r_blink_cnt;
   logic [LIM_W-1:0]   r_green_lim [NUM_DIR];
   logic [LIM_W-1:0]   r_yellow_lim;
   logic [LIM_W-1:0]   r_all_red_lim;
   logic [LIM_W-1:0]   w_limit;
   logic [LIM_W-1:0]   w_cmd_cyc;
   logic               w_phase_done;
   logic               w_phase_clr;
   logic               w_restart;
   logic               w_blink_on;
   logic               w_blink_state;
   logic               w_scan_found;
   logic [DIR_W-1:0]   w_scan_dir;

   assign w_cmd_cyc     = LIM_W'(cmd_data_i) * LIM_W'(CLK_FREQ_KHZ);
   assign w_blink_on    = (r_blink_cnt < BLINK_HALF_CYC);
   assign w_blink_state = (r_state == ST_GREEN_BLINK) || (r_state == ST_MANUAL);
   // A zero limit still gives a one-cycle phase, and a lowered limit ends the phase at once.
   assign w_phase_done  = ({1'b0, r_cnt} + 18'd1) >= {1'b0, w_limit};
   assign w_phase_clr   = (w_state_next != r_state) || w_restart;
   assign active_dir_o  = r_dir;

   always_comb begin
      w_limit = '1;
      case (r_state)
         ST_ALL_RED:     w_limit = r_all_red_lim;
         ST_RED_YELLOW:  w_limit = RED_YELLOW_CYC;
         ST_GREEN:       w_limit = r_green_lim[r_dir];
         ST_GREEN_BLINK: w_limit = GREEN_BLINK_CYC;
         ST_YELLOW:      w_limit = r_yellow_lim;
         default:        w_limit = '1;
      endcase
   end

   // Lowest offset from the current direction wins, so scan downwards and overwrite.
   always_comb begin
      w_scan_found = 1'b0;
      w_scan_dir   = r_dir;
      for (int i = NUM_DIR - 1; i >= 0; i--) begin
         if (r_green_lim[DIR_W'((int'(r_dir) + i) % NUM_DIR)] != '0) begin
            w_scan_found = 1'b1;
            w_scan_dir   = DIR_W'((int'(r_dir) + i) % NUM_DIR);
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_dir_next   = r_dir;
      w_restart    = 1'b0;
      case (r_state)
         ST_ALL_RED: begin
            if (w_phase_done) begin
               if (w_scan_found) begin
                  w_state_next = ST_RED_YELLOW;
                  w_dir_next   = w_scan_dir;
               end else begin
                  w_restart = 1'b1;
               end
            end
         end
         ST_RED_YELLOW:  if (w_phase_done) w_state_next = ST_GREEN;
         ST_GREEN:       if (w_phase_done) w_state_next = ST_GREEN_BLINK;
         ST_GREEN_BLINK: if (w_phase_done) w_state_next = ST_YELLOW;
         ST_YELLOW: begin
            if (w_phase_done) begin
               w_state_next = ST_ALL_RED;
               w_dir_next   = (r_dir == DIR_LAST) ? '0 : r_dir + DIR_W'(1);
            end
         end
         default: ;
      endcase
      if (cmd_valid_i) begin
         case (cmd_type_i)
            CMD_OFF: begin
               w_state_next = ST_OFF;
               w_dir_next   = r_dir;
            end
            CMD_MANUAL: begin
               w_state_next = ST_MANUAL;
               w_dir_next   = r_dir;
            end
            CMD_ON: begin
               if ((r_state == ST_OFF) || (r_state == ST_MANUAL)) begin
                  w_state_next = ST_ALL_RED;
                  w_dir_next   = '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_2k_i) begin
      if (srst_i) begin
         r_state       <= ST_ALL_RED;
         r_dir         <= '0;
         r_cnt         <= '0;
         r_blink_cnt   <= '0;
         r_yellow_lim  <= DEF_YELLOW_CYC;
         r_all_red_lim <= DEF_ALL_RED_CYC;
         for (int i = 0; i < NUM_DIR; i++) r_green_lim[i] <= DEF_GREEN_CYC;
      end else begin
         r_state <= w_state_next;
         r_dir   <= w_dir_next;
         r_cnt   <= w_phase_clr ? '0 : r_cnt + LIM_W'(1);
         if (w_phase_clr || !w_blink_state || (r_blink_cnt == BLINK_LAST_CYC)) begin
            r_blink_cnt <= '0;
         end else begin
            r_blink_cnt <= r_blink_cnt + LIM_W'(1);
         end
         if (cmd_valid_i) begin
            case (cmd_type_i)
               CMD_SET_GREEN: begin
                  if (int'(cmd_dir_i) < NUM_DIR) r_green_lim[cmd_dir_i] <= w_cmd_cyc;
               end
               CMD_SET_YELLOW:  r_yellow_lim  <= w_cmd_cyc;
               CMD_SET_ALL_RED: r_all_red_lim <= w_cmd_cyc;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      red_o    = '1;
      yellow_o = '0;
      green_o  = '0;
      case (r_state)
         ST_RED_YELLOW: yellow_o[r_dir] = 1'b1;
         ST_GREEN: begin
            red_o[r_dir]   = 1'b0;
            green_o[r_dir] = 1'b1;
         end
         ST_GREEN_BLINK: begin
            red_o[r_dir]   = 1'b0;
            green_o[r_dir] = w_blink_on;
         end
         ST_YELLOW: begin
            red_o[r_dir]    = 1'b0;
            yellow_o[r_dir] = 1'b1;
         end
         ST_MANUAL: begin
            red_o    = '0;
            yellow_o = {NUM_DIR{w_blink_on}};
         end
         ST_OFF:  red_o = '0;
         default: ;
      endcase
   end

endmodule
`default_nettype wire
